// File: rtl/calendar_counter.sv
// Purpose : registered year/month/day calendar; advances one day per tick, supports a checked synchronous load.
// Latency : date and carry/error pulses update one cycle after the tick/load edge; days_in_month/big_month are combinational.
// Backpressure: none; tick and load are accepted every cycle, and load takes priority over a simultaneous tick.
//
// Optional feature: define LEAP_YEAR_EN to give February 29 days in Gregorian leap years
// (affects both counting and load validation). Without it February is always 28 days.
//
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   tick                - advance-one-day pulse
//   load, ld_year/ld_month/ld_day - synchronous load request and date to load
//   year, month, day    - current date (registered)
//   days_in_month       - length of the current month (combinational)
//   big_month           - current month has 31 days (combinational)
//   month_carry         - one-cycle pulse: the previous tick rolled the month over
//   year_carry          - one-cycle pulse: the previous tick rolled the year over
//   load_err            - one-cycle pulse: the previous load was rejected
module calendar_counter #(
  parameter int YEAR_W      = 12,
  parameter int RESET_YEAR  = 2000,
  parameter int RESET_MONTH = 1,
  parameter int RESET_DAY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic [3:0]        ld_month,
  input  logic [4:0]        ld_day,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [4:0]        days_in_month,
  output logic              big_month,
  output logic              month_carry,
  output logic              year_carry,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] RST_YEAR  = YEAR_W'(RESET_YEAR);
  localparam logic [3:0]        RST_MONTH = 4'(RESET_MONTH);
  localparam logic [4:0]        RST_DAY   = 5'(RESET_DAY);

  // Month length for month m; leap only matters for February.
  // Out-of-range months return 0 so any day fails the load range check.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    logic [4:0] len;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
      4'd2:                                       len = leap ? 5'd29 : 5'd28;
      default:                                    len = 5'd0;
    endcase
    return len;
  endfunction

`ifdef LEAP_YEAR_EN
  // Gregorian rule on the unsigned year value.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    return ((v % 32'd4) == 32'd0) &&
           (((v % 32'd100) != 32'd0) || ((v % 32'd400) == 32'd0));
  endfunction
`endif

  logic [YEAR_W-1:0] year_q, year_d;
  logic [3:0]        month_q, month_d;
  logic [4:0]        day_q, day_d;
  logic              month_carry_q, month_carry_d;
  logic              year_carry_q, year_carry_d;
  logic              load_err_q, load_err_d;

  logic       cur_leap;
  logic       ld_leap;
  logic [4:0] cur_len;
  logic [4:0] ld_len;
  logic       ld_ok;

  always_comb begin
`ifdef LEAP_YEAR_EN
    cur_leap = is_leap(year_q);
    ld_leap  = is_leap(ld_year);
`else
    cur_leap = 1'b0;
    ld_leap  = 1'b0;
`endif
    cur_len = month_len(month_q, cur_leap);
    // Load is validated against the requested month/year, not the current date.
    ld_len  = month_len(ld_month, ld_leap);
    ld_ok   = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
              (ld_day >= 5'd1) && (ld_day <= ld_len);
  end

  always_comb begin
    year_d        = year_q;
    month_d       = month_q;
    day_d         = day_q;
    month_carry_d = 1'b0;
    year_carry_d  = 1'b0;
    load_err_d    = 1'b0;

    if (load) begin
      // Load wins over tick; a rejected load leaves the date alone and drops the tick too.
      if (ld_ok) begin
        year_d  = ld_year;
        month_d = ld_month;
        day_d   = ld_day;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d         = 5'd1;
        month_carry_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d      = 4'd1;
          // Wraps modulo 2^YEAR_W by plain overflow.
          year_d       = year_q + YEAR_W'(1);
          year_carry_d = 1'b1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year_q        <= RST_YEAR;
      month_q       <= RST_MONTH;
      day_q         <= RST_DAY;
      month_carry_q <= 1'b0;
      year_carry_q  <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      year_q        <= year_d;
      month_q       <= month_d;
      day_q         <= day_d;
      month_carry_q <= month_carry_d;
      year_carry_q  <= year_carry_d;
      load_err_q    <= load_err_d;
    end
  end

  always_comb begin
    big_month = 1'b0;
    case (month_q)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: big_month = 1'b1;
      default:                                    big_month = 1'b0;
    endcase
  end

  assign days_in_month = cur_len;
  assign year          = year_q;
  assign month         = month_q;
  assign day           = day_q;
  assign month_carry   = month_carry_q;
  assign year_carry    = year_carry_q;
  assign load_err      = load_err_q;

endmodule
